// File: rtl/weight_sram_arbiter_if.sv
// Shared-port bundle between one weight SRAM macro, its arbiter and the three clients
// (DMA weight writer, conv reader, FC reader).
interface weight_sram_arbiter_if #(
   parameter int unsigned AW = 11,
   parameter int unsigned DW = 16
);
   logic          dma_mode;
   logic [AW:0]   load_len;

   logic          dma_req;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic          dma_gnt;

   logic          conv_req;
   logic [AW-1:0] conv_addr;
   logic          conv_gnt;
   logic          conv_rvalid;
   logic [DW-1:0] conv_rdata;

   logic          fc_req;
   logic [AW-1:0] fc_addr;
   logic          fc_gnt;
   logic          fc_rvalid;
   logic [DW-1:0] fc_rdata;

   logic          sram_cen;
   logic [DW-1:0] sram_wen;
   logic [AW-1:0] sram_a;
   logic [DW-1:0] sram_d;
   logic [DW-1:0] sram_q;

   logic [AW:0]   wr_count;
   logic          load_done;
   logic          err_overrun;

   // Arbiter side.
   modport slave (
      input  dma_mode, load_len,
      input  dma_req, dma_addr, dma_wdata,
      output dma_gnt,
      input  conv_req, conv_addr,
      output conv_gnt, conv_rvalid, conv_rdata,
      input  fc_req, fc_addr,
      output fc_gnt, fc_rvalid, fc_rdata,
      output sram_cen, sram_wen, sram_a, sram_d,
      input  sram_q,
      output wr_count, load_done, err_overrun
   );

   // Client / SRAM side.
   modport master (
      output dma_mode, load_len,
      output dma_req, dma_addr, dma_wdata,
      input  dma_gnt,
      output conv_req, conv_addr,
      input  conv_gnt, conv_rvalid, conv_rdata,
      output fc_req, fc_addr,
      input  fc_gnt, fc_rvalid, fc_rdata,
      input  sram_cen, sram_wen, sram_a, sram_d,
      output sram_q,
      input  wr_count, load_done, err_overrun
   );
endinterface

// File: rtl/weight_sram_arbiter.sv
// Single-port weight SRAM arbiter: DMA-only writes during load, round-robin conv/FC reads
// during inference, with a load-length counter and overrun flag.
module weight_sram_arbiter #(
   parameter int unsigned AW = 11,
   parameter int unsigned DW = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   weight_sram_arbiter_if.slave  bus
);
   localparam logic [AW:0] CntMax = '1;

   logic          dma_mode_q;
   logic          rr_last_fc_q;
   logic [1:0]    tag_q;
   logic [AW-1:0] a_q;
   logic [DW-1:0] d_q;
   logic [AW:0]   wr_count_q, wr_count_d;
   logic [AW:0]   load_len_q, load_len_d;
   logic [AW:0]   cnt_base;
   logic          load_done_q, load_done_d;
   logic          err_q, err_d;
   logic          mode_rise;

   logic          dma_gnt, conv_gnt, fc_gnt, any_gnt;
   logic [AW-1:0] sram_a;
   logic [DW-1:0] sram_d;

   // Grants are combinational and forced off while reset is held.
   always_comb begin
      dma_gnt  = 1'b0;
      conv_gnt = 1'b0;
      fc_gnt   = 1'b0;
      if (rst_n) begin
         if (bus.dma_mode) begin
            dma_gnt = bus.dma_req;
         end else begin
            conv_gnt = bus.conv_req & (~bus.fc_req | rr_last_fc_q);
            fc_gnt   = bus.fc_req & (~bus.conv_req | ~rr_last_fc_q);
         end
      end
   end

   assign any_gnt = dma_gnt | conv_gnt | fc_gnt;

   // Idle cycles replay the shadow address/data so the macro pins stay quiet.
   always_comb begin
      sram_a = a_q;
      sram_d = d_q;
      if (dma_gnt) begin
         sram_a = bus.dma_addr;
         sram_d = bus.dma_wdata;
      end else if (conv_gnt) begin
         sram_a = bus.conv_addr;
      end else if (fc_gnt) begin
         sram_a = bus.fc_addr;
      end
   end

   assign bus.dma_gnt  = dma_gnt;
   assign bus.conv_gnt = conv_gnt;
   assign bus.fc_gnt   = fc_gnt;
   assign bus.sram_cen = ~any_gnt;
   assign bus.sram_wen = {DW{~dma_gnt}};
   assign bus.sram_a   = sram_a;
   assign bus.sram_d   = sram_d;

   // A write granted in the rising-edge cycle is the first write of the new phase.
   always_comb begin
      mode_rise   = bus.dma_mode & ~dma_mode_q;
      cnt_base    = mode_rise ? '0 : wr_count_q;
      load_len_d  = mode_rise ? bus.load_len : load_len_q;
      err_d       = mode_rise ? 1'b0 : err_q;
      wr_count_d  = cnt_base;
      load_done_d = 1'b0;
      if (dma_gnt) begin
         if (cnt_base >= load_len_d) begin
            err_d = 1'b1;
         end
         if (cnt_base != CntMax) begin
            wr_count_d  = cnt_base + 1'b1;
            load_done_d = (wr_count_d == load_len_d);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dma_mode_q   <= 1'b0;
         rr_last_fc_q <= 1'b1;
         tag_q        <= 2'b00;
         a_q          <= '0;
         d_q          <= '0;
         wr_count_q   <= '0;
         load_len_q   <= '0;
         load_done_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         dma_mode_q  <= bus.dma_mode;
         tag_q       <= {conv_gnt, fc_gnt};
         if (conv_gnt) begin
            rr_last_fc_q <= 1'b0;
         end else if (fc_gnt) begin
            rr_last_fc_q <= 1'b1;
         end
         if (any_gnt) begin
            a_q <= sram_a;
         end
         if (dma_gnt) begin
            d_q <= bus.dma_wdata;
         end
         wr_count_q  <= wr_count_d;
         load_len_q  <= load_len_d;
         load_done_q <= load_done_d;
         err_q       <= err_d;
      end
   end

   assign bus.conv_rvalid = tag_q[1];
   assign bus.fc_rvalid   = tag_q[0];
   assign bus.conv_rdata  = bus.sram_q;
   assign bus.fc_rdata    = bus.sram_q;
   assign bus.wr_count    = wr_count_q;
   assign bus.load_done   = load_done_q;
   assign bus.err_overrun = err_q;
endmodule

// File: tb/tb_weight_sram_arbiter.sv
// Randomized bench for weight_sram_arbiter: SRAM behavioural model plus a transaction-level
// reference of grants, read returns and the load counter.
module tb_weight_sram_arbiter;
   localparam int AW = 11;
   localparam int DW = 16;
   localparam int CNT_MAX = (1 << (AW + 1)) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   weight_sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   weight_sram_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
      return ({5'd0, a} * 16'h9E37) ^ 16'h5A5A;
   endfunction

   // SRAM macro: 1-cycle read latency, unwritten words hold preloaded contents.
   bit          written [0:(1<<AW)-1];
   logic [DW-1:0] mem   [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.sram_cen == 1'b0) begin
         if (bus.sram_wen == '0) begin
            mem[bus.sram_a]     <= bus.sram_d;
            written[bus.sram_a] <= 1'b1;
         end else begin
            bus.sram_q <= written[bus.sram_a] ? mem[bus.sram_a] : preload(bus.sram_a);
         end
      end
   end

   // Reference model state.
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   bit            m_last_fc;
   bit            m_rv_conv, m_rv_fc;
   logic [DW-1:0] m_rdata;
   logic [AW-1:0] m_sh_a;
   logic [DW-1:0] m_sh_d;
   int            m_count, m_len;
   bit            m_done, m_err, m_prev_mode;
   bit            g_dma, g_conv, g_fc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_last_fc   = 1'b1;
      m_rv_conv   = 1'b0;
      m_rv_fc     = 1'b0;
      m_sh_a      = '0;
      m_sh_d      = '0;
      m_count     = 0;
      m_len       = 0;
      m_done      = 1'b0;
      m_err       = 1'b0;
      m_prev_mode = 1'b0;
   endtask

   // Called just after a falling edge with the cycle's inputs applied.
   task automatic eval();
      bit            e_dma, e_conv, e_fc;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_d;
      #1;
      if (!rst_n) model_reset();

      check("conv_rvalid", 32'(bus.conv_rvalid), 32'(m_rv_conv));
      check("fc_rvalid", 32'(bus.fc_rvalid), 32'(m_rv_fc));
      if (m_rv_conv) check("conv_rdata", 32'(bus.conv_rdata), 32'(m_rdata));
      if (m_rv_fc) check("fc_rdata", 32'(bus.fc_rdata), 32'(m_rdata));
      check("wr_count", 32'(bus.wr_count), 32'(m_count));
      check("load_done", 32'(bus.load_done), 32'(m_done));
      check("err_overrun", 32'(bus.err_overrun), 32'(m_err));

      e_dma  = 1'b0;
      e_conv = 1'b0;
      e_fc   = 1'b0;
      if (rst_n) begin
         if (bus.dma_mode) begin
            e_dma = bus.dma_req;
         end else if (bus.conv_req && bus.fc_req) begin
            if (m_last_fc) e_conv = 1'b1;
            else e_fc = 1'b1;
         end else begin
            e_conv = bus.conv_req;
            e_fc   = bus.fc_req;
         end
      end
      e_a = e_dma ? bus.dma_addr : e_conv ? bus.conv_addr : e_fc ? bus.fc_addr : m_sh_a;
      e_d = e_dma ? bus.dma_wdata : m_sh_d;

      check("dma_gnt", 32'(bus.dma_gnt), 32'(e_dma));
      check("conv_gnt", 32'(bus.conv_gnt), 32'(e_conv));
      check("fc_gnt", 32'(bus.fc_gnt), 32'(e_fc));
      check("sram_cen", 32'(bus.sram_cen), 32'(!(e_dma || e_conv || e_fc)));
      check("sram_wen", 32'(bus.sram_wen), e_dma ? 32'h0 : 32'hFFFF);
      check("sram_a", 32'(bus.sram_a), 32'(e_a));
      check("sram_d", 32'(bus.sram_d), 32'(e_d));

      g_dma  = e_dma;
      g_conv = e_conv;
      g_fc   = e_fc;
      if (!rst_n) return;

      m_rv_conv = e_conv;
      m_rv_fc   = e_fc;
      if (e_conv) begin
         m_rdata   = ref_mem[bus.conv_addr];
         m_last_fc = 1'b0;
      end
      if (e_fc) begin
         m_rdata   = ref_mem[bus.fc_addr];
         m_last_fc = 1'b1;
      end
      if (bus.dma_mode && !m_prev_mode) begin
         m_count = 0;
         m_len   = int'(bus.load_len);
         m_err   = 1'b0;
      end
      m_done = 1'b0;
      if (e_dma) begin
         if (m_count >= m_len) m_err = 1'b1;
         if (m_count < CNT_MAX) begin
            m_count++;
            if (m_count == m_len) m_done = 1'b1;
         end
         ref_mem[bus.dma_addr] = bus.dma_wdata;
         m_sh_d = bus.dma_wdata;
      end
      if (e_dma || e_conv || e_fc) m_sh_a = e_a;
      m_prev_mode = bus.dma_mode;
   endtask

   // Requests are held until granted; a freshly issued one gets a new address.
   task automatic randomize_inputs();
      if ($urandom_range(0, 19) == 0) bus.dma_mode = ~bus.dma_mode;
      bus.load_len = 12'($urandom_range(0, 6));
      if (!bus.dma_req || g_dma) begin
         bus.dma_req   = ($urandom_range(0, 2) != 0);
         bus.dma_addr  = 11'($urandom_range(0, 15));
         bus.dma_wdata = 16'($urandom);
      end
      if (!bus.conv_req || g_conv) begin
         bus.conv_req  = ($urandom_range(0, 1) != 0);
         bus.conv_addr = 11'($urandom_range(0, 15));
      end
      if (!bus.fc_req || g_fc) begin
         bus.fc_req  = ($urandom_range(0, 1) != 0);
         bus.fc_addr = 11'($urandom_range(0, 15));
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = preload(11'(i));
      model_reset();
      g_dma = 1'b0; g_conv = 1'b0; g_fc = 1'b0;
      bus.dma_mode = 1'b0; bus.load_len = '0;
      bus.dma_req = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
      bus.conv_req = 1'b0; bus.conv_addr = '0;
      bus.fc_req = 1'b0; bus.fc_addr = '0;

      repeat (3) begin
         @(negedge clk);
         eval();
      end

      // Both readers continuously requesting: conv, fc, conv, fc.
      @(negedge clk);
      rst_n = 1'b1;
      bus.conv_req = 1'b1; bus.conv_addr = 11'd1;
      bus.fc_req = 1'b1; bus.fc_addr = 11'd2;
      eval();
      repeat (4) begin
         @(negedge clk);
         eval();
      end

      // Load 4 words, then a 5th write overruns; a new phase clears the flag.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.conv_req = 1'b0; bus.fc_req = 1'b0;
         bus.dma_mode = 1'b1; bus.load_len = 12'd4;
         bus.dma_req = 1'b1; bus.dma_addr = 11'(i); bus.dma_wdata = 16'hA000 + 16'(i);
         eval();
      end
      @(negedge clk);
      bus.dma_req = 1'b0; bus.dma_mode = 1'b0;
      eval();
      repeat (2) begin
         @(negedge clk);
         bus.dma_mode = 1'b1;
         eval();
      end
      @(negedge clk);
      bus.dma_mode = 1'b0;
      bus.conv_req = 1'b1; bus.conv_addr = 11'd3;
      eval();

      // Reset asserted before the edge that would return the conv read.
      @(negedge clk);
      bus.conv_req = 1'b1; bus.conv_addr = 11'd5;
      eval();
      #2 rst_n = 1'b0;
      @(negedge clk);
      bus.conv_req = 1'b0;
      eval();
      @(negedge clk);
      rst_n = 1'b1;
      eval();

      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         randomize_inputs();
         eval();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/weight_sram_arbiter.md
# weight_sram_arbiter

Single-port arbiter for one weight SRAM macro (RAMSP-style: active-low CEN/WEN, 1-cycle read latency), shared between the DMA weight writer, the conv-layer weight reader and the FC weight reader. During weight load (`dma_mode=1`) only the DMA port is served, and the block counts accepted writes against a programmed length. In inference (`dma_mode=0`) the conv and FC readers are served round-robin, and read data is routed back to the requester that issued the read. One instance sits in front of each weight SRAM, replacing the ad-hoc `dma_start ? dma_addr : engine_addr` muxing.

## Interface

Parameters:
- `AW`, 11: SRAM address width.
- `DW`, 16: SRAM data width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `dma_mode`  in  1  1 = load phase (DMA only); 0 = inference (readers only).
- `load_len`  in  AW+1  number of DMA writes expected per load phase; sampled on `dma_mode` rising edge.
- `dma_req`  in  1  DMA write request; held with addr/data until granted.
- `dma_addr`  in  AW  DMA write address.
- `dma_wdata`  in  DW  DMA write data.
- `dma_gnt`  out  1  DMA write accepted this cycle.
- `conv_req` / `fc_req`  in  1  read request; held with its address until granted.
- `conv_addr` / `fc_addr`  in  AW  read address.
- `conv_gnt` / `fc_gnt`  out  1  read accepted this cycle.
- `conv_rvalid` / `fc_rvalid`  out  1  read data valid (one cycle after the grant).
- `conv_rdata` / `fc_rdata`  out  DW  read data; equals `sram_q`, meaningful only while the matching rvalid is high.
- `sram_cen`  out  1  SRAM chip enable, active-low.
- `sram_wen`  out  DW  SRAM per-bit write enable, active-low (all bits identical).
- `sram_a`  out  AW  SRAM address.
- `sram_d`  out  DW  SRAM write data.
- `sram_q`  in  DW  SRAM read data, valid the cycle after the access.
- `wr_count`  out  AW+1  DMA writes accepted since the last `dma_mode` rise.
- `load_done`  out  1  one-cycle pulse when `wr_count` reaches `load_len`.
- `err_overrun`  out  1  sticky; a DMA write was accepted with `wr_count >= load_len`.

## Operation

- Grant decision is combinational from the current-cycle requests, `dma_mode` and the `rr_last` register. At most one grant per cycle.
- Load phase (`dma_mode=1`):
  - `dma_gnt = dma_req`; `conv_gnt = fc_gnt = 0`.
  - On a DMA grant: `sram_cen=0`, `sram_wen=0`, `sram_a=dma_addr`, `sram_d=dma_wdata`.
- Inference phase (`dma_mode=0`):
  - `dma_gnt=0`.
  - Exactly one reader requesting: it is granted.
  - Both requesting: grant the reader not equal to `rr_last`. `rr_last` updates to the granted reader on every read grant.
  - On a read grant: `sram_cen=0`, `sram_wen` all 1, `sram_a` = granted address.
- No grant in a cycle: `sram_cen=1`, `sram_wen` all 1, `sram_a`/`sram_d` hold their last values (registered shadow), so there is no address toggling.
- Read tag: a registered 2-bit `{conv, fc}` one-hot records which reader was granted; the next cycle the matching rvalid is high. Both rdata outputs are wired directly to `sram_q`.
- Load counter:
  - On `dma_mode` 0→1: `wr_count` clears to 0, `load_len` is latched, `err_overrun` clears.
  - Each DMA grant increments `wr_count`, saturating at all-ones.
  - `load_done` pulses in the cycle after the grant that makes `wr_count == latched load_len`.
  - If latched `load_len == 0`, `load_done` never pulses and the first write sets `err_overrun`.
  - A DMA grant while `wr_count >= latched load_len` sets `err_overrun`.
- Mode switch mid-stream:
  - A read granted in the last inference cycle still returns its rvalid in the next cycle, even if `dma_mode=1` by then.
  - A pending (ungranted) request simply waits for its phase.
  - `wr_count` holds its value while `dma_mode=0`.
- Reset, asynchronous, at any time:
  - `rr_last` = fc, so conv wins the first tie.
  - Read tag = 0, `wr_count` = 0, latched `load_len` = 0, `err_overrun` = 0, `load_done` = 0.
  - Address/data shadows = 0.
  - While `rst_n=0`, all gnts are forced 0 and `sram_cen=1`, `sram_wen` all 1.
  - A read in flight at reset assertion produces no rvalid.

## Timing

- Request → grant: 0 cycles (same cycle, combinational).
- Grant → rvalid/rdata: exactly 1 cycle.
- Sustained throughput: 1 access per cycle. With both readers continuously requesting, grants alternate conv, fc, conv, … starting with conv after reset.
- DMA grant in cycle N → `wr_count` updated at edge N+1. If equality is reached, `load_done` is high during cycle N+1 only.
- `dma_mode` rise in cycle N: the counter clear happens at edge N+1. A DMA write granted in cycle N counts as the first write of the new phase (count = 1 after the edge).
- All outputs other than the gnts and SRAM controls are registered.

## Test plan

- Load 4 words: `load_len=4`, DMA writes 0xA000..0xA003 to addresses 0..3 on consecutive cycles → 4 write strobes with `sram_wen=0`; `wr_count` steps 1..4; one `load_done` pulse the cycle after the 4th grant; `err_overrun=0`.
- Overrun: same sequence, then a 5th write → `err_overrun=1` and it stays high; a new `dma_mode` rise clears it and zeroes `wr_count`.
- Round-robin: after reset, conv and fc request continuously at addresses 1 and 2 → grant order conv, fc, conv, fc; `conv_rvalid`/`fc_rvalid` alternate one cycle later with the correct preloaded data.
- Phase gating: `dma_mode=1` while `conv_req` is held → no conv grant and `sram_cen` low only for DMA. Drop `dma_mode` → conv is granted the same cycle.
- Mode switch in flight: fc granted in the last inference cycle, `dma_mode` rises next cycle → `fc_rvalid` is still asserted with the correct data, and the DMA grant proceeds in that same cycle.
- Reset mid-read: assert `rst_n` low in the cycle after a conv grant → no `conv_rvalid`. After release, all outputs are at their reset values and `sram_cen=1`.
